// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory pipeline stage.
//   state_e           : access FSM states
//   DefaultBaseAddr   : byte address that maps to data-memory word 0
//   DefaultMaxWait    : BUSY cycles tolerated without ack before timeout
//   TimeoutFill       : read-data value loaded when a read times out
package mem_stage_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  localparam logic [31:0] DefaultBaseAddr = 32'd1024;
  localparam int unsigned DefaultMaxWait  = 15;
  localparam logic [31:0] TimeoutFill     = 32'hDEADBEEF;

  // Wide enough for the largest legal MAX_WAIT (255).
  localparam int unsigned WaitCntW = 8;

endpackage

// File: rtl/register.sv
// Generic enabled register with asynchronous active-low reset.
//   clk_i  : clock
//   rst_ni : asynchronous reset, active low, loads ResetVal
//   en_i   : load enable
//   d_i    : next value
//   q_o    : stored value
module register #(
  parameter int unsigned      Width    = 32,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_o <= ResetVal;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: turns load/store requests from the EXE register into a
// handshaked data-memory access and stalls the pipeline until it completes.
//   clk, rst                 : clock, asynchronous active-low reset
//   WB_en_in .. Dest_in      : controls / data from the EXE pipeline register
//   WB_en_out .. Dest_out    : controls / data to the MEM/WB register
//   freeze                   : stall request to upstream registers and the PC
//   mem_req/we/addr/wdata    : request to data memory (word address)
//   mem_rdata, mem_ack       : response from data memory (ack is a 1-cycle pulse)
//   mem_err                  : 1-cycle pulse when an access times out
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DefaultBaseAddr,
  parameter int unsigned MAX_WAIT  = DefaultMaxWait
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_en_in,
  input  logic        MEM_R_EN_in,
  input  logic        MEM_W_EN_in,
  input  logic [31:0] ALU_result_in,
  input  logic [31:0] ST_val_in,
  input  logic [3:0]  Dest_in,
  output logic        WB_en_out,
  output logic        MEM_R_EN_out,
  output logic [31:0] ALU_result_out,
  output logic [31:0] MEM_result_out,
  output logic [3:0]  Dest_out,
  output logic        freeze,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_err
);

  localparam logic [WaitCntW-1:0] MaxWaitCnt = WaitCntW'(MAX_WAIT);

  state_e              state_q, state_d;
  logic [WaitCntW-1:0] cnt_q, cnt_d;

  logic        access;
  logic        busy;
  logic        cap_en;
  logic        rd_en;
  logic        timeout;
  logic [31:0] addr_d, addr_q;
  logic [31:0] wdata_q;
  logic        we_d, we_q;
  logic [31:0] rd_d, rd_q;

  assign access = MEM_R_EN_in | MEM_W_EN_in;
  assign busy   = (state_q == StBusy);
  // Modulo-2^32 subtract: addresses below BASE_ADDR wrap rather than fault.
  assign addr_d = (ALU_result_in - BASE_ADDR) >> 2;
  // Read wins when both enables are set.
  assign we_d   = MEM_W_EN_in & ~MEM_R_EN_in;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_en  = 1'b0;
    rd_en   = 1'b0;
    rd_d    = mem_rdata;
    timeout = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (access) begin
          cap_en  = 1'b1;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (mem_ack) begin
          rd_en   = ~we_q;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == MaxWaitCnt) begin
            timeout = 1'b1;
            rd_en   = ~we_q;
            rd_d    = TimeoutFill;
            state_d = StDone;
          end
        end
      end
      // Always return to IDLE so the same instruction cannot start a second access.
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  register #(
    .Width(32)
  ) u_addr_reg (
    .clk_i (clk),
    .rst_ni(rst),
    .en_i  (cap_en),
    .d_i   (addr_d),
    .q_o   (addr_q)
  );

  register #(
    .Width(32)
  ) u_wdata_reg (
    .clk_i (clk),
    .rst_ni(rst),
    .en_i  (cap_en),
    .d_i   (ST_val_in),
    .q_o   (wdata_q)
  );

  register #(
    .Width(1)
  ) u_we_reg (
    .clk_i (clk),
    .rst_ni(rst),
    .en_i  (cap_en),
    .d_i   (we_d),
    .q_o   (we_q)
  );

  register #(
    .Width(32)
  ) u_rdata_reg (
    .clk_i (clk),
    .rst_ni(rst),
    .en_i  (rd_en),
    .d_i   (rd_d),
    .q_o   (rd_q)
  );

  // Request outputs decode straight from state so reset drops them without a clock.
  assign mem_req   = busy;
  assign mem_we    = busy & we_q;
  assign mem_addr  = busy ? addr_q : '0;
  assign mem_wdata = busy ? wdata_q : '0;
  assign mem_err   = timeout;

  assign freeze         = busy | ((state_q == StIdle) & access);
  assign WB_en_out      = WB_en_in & ~freeze;
  assign MEM_R_EN_out   = MEM_R_EN_in;
  assign ALU_result_out = ALU_result_in;
  assign Dest_out       = Dest_in;
  assign MEM_result_out = rd_q;

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 BASE_ADDR, default 32'd1024: byte address mapped to data-memory word 0.
REQ-002 MAX_WAIT, default 15: BUSY cycles without ack before timeout; legal range 1..255.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-low (0 = reset).
REQ-005 WB_en_in, MEM_R_EN_in, MEM_W_EN_in  in  1 each  controls from the EXE pipeline register.
REQ-006 ALU_result_in  in  32  effective byte address, or ALU result for non-memory ops.
REQ-007 ST_val_in  in  32  store data; Dest_in  in  4  destination register index.
REQ-008 WB_en_out, MEM_R_EN_out  out  1 each  controls to the MEM/WB register.
REQ-009 ALU_result_out  out  32; MEM_result_out  out  32; Dest_out  out  4.
REQ-010 freeze  out  1  stall request to all upstream pipeline registers and the PC.
REQ-011 mem_req  out  1; mem_we  out  1; mem_addr  out  32 (word address); mem_wdata  out  32.
REQ-012 mem_rdata  in  32; mem_ack  in  1  one-cycle completion pulse from data memory.
REQ-013 mem_err  out  1  one-cycle pulse on access timeout.

Function
REQ-014 The block SHALL implement FSM states IDLE, BUSY, DONE.
REQ-015 An access SHALL exist when MEM_R_EN_in | MEM_W_EN_in is 1. If both are 1, the access SHALL be a read (mem_we=0).
REQ-016 IDLE with access: freeze=1 combinationally. On the clock edge, the block SHALL capture addr=(ALU_result_in-BASE_ADDR)>>2 (32-bit modulo, no range check), ST_val_in and we=MEM_W_EN_in&~MEM_R_EN_in, clear the wait counter, and move to BUSY.
REQ-017 IDLE without access: freeze=0; the FSM SHALL remain in IDLE.
REQ-018 BUSY: mem_req=1 and freeze=1. mem_addr, mem_wdata and mem_we SHALL be driven from the captured registers and held stable until mem_ack.
REQ-019 BUSY with mem_ack=1: the block SHALL load mem_rdata into the read-data register if the access is a read, and move to DONE.
REQ-020 BUSY with mem_ack=0: the wait counter SHALL increment. When the counter equals MAX_WAIT, the block SHALL pulse mem_err on that cycle, load read-data with 32'hDEADBEEF if the access is a read, and move to DONE. mem_ack takes priority on that same cycle.
REQ-021 DONE: freeze=0 and mem_req=0; the FSM SHALL go to IDLE unconditionally. This prevents a second access by the same instruction.
REQ-022 mem_req, mem_we, mem_addr and mem_wdata SHALL be 0 in IDLE and DONE.
REQ-023 mem_ack in IDLE or DONE SHALL be ignored.
REQ-024 ALU_result_out, Dest_out and MEM_R_EN_out SHALL pass through combinationally from their inputs.
REQ-025 WB_en_out SHALL equal WB_en_in & ~freeze, so a bubble enters writeback while stalled.
REQ-026 MEM_result_out SHALL always reflect the read-data register.
REQ-027 Latency: a memory access with ack k cycles after BUSY entry SHALL take k+2 cycles (IDLE, k BUSY cycles, DONE). A non-memory op SHALL take 0 added cycles.

Reset
REQ-028 On rst=0 the block SHALL asynchronously force: state IDLE, wait counter 0, captured addr/wdata/we 0, read-data 0, mem_req 0, mem_err 0.
REQ-029 Reset asserted during BUSY SHALL drop mem_req immediately without waiting for a clock. A late mem_ack after reset SHALL be ignored.

Structure
REQ-030 A shared package SHALL hold the state enumeration, the default BASE_ADDR, and the timeout fill value 32'hDEADBEEF.
REQ-031 Captured address, data and read-data SHALL use the existing generic parameterised register sub-module, named register. The FSM and the counter SHALL be inline.

Verification
REQ-032 Non-memory op (R=W=0, ALU_result_in=0x55, WB_en_in=1) -> freeze=0, WB_en_out=1, ALU_result_out=0x55, mem_req stays 0.
REQ-033 Load from ALU_result_in=1024+8, ack on 3rd BUSY cycle with rdata=0x12345678 -> mem_addr=2, freeze=1 for 4 cycles, MEM_result_out=0x12345678 in DONE, WB_en_out=1 only in DONE.
REQ-034 Store of 0xCAFEF00D to 1024+4, immediate ack -> mem_we=1, mem_addr=1, mem_wdata=0xCAFEF00D, total 3 cycles, MEM_result_out unchanged.
REQ-035 Load with ack never asserted, MAX_WAIT=15 -> mem_err pulses once on the 15th BUSY cycle, MEM_result_out=0xDEADBEEF, FSM returns to IDLE.
REQ-036 R=W=1 -> mem_we=0 and a read is performed. Separately, ALU_result_in=0 -> mem_addr=0x3FFFFF00 (wrap).
REQ-037 rst=0 pulsed mid-BUSY, then mem_ack after release -> mem_req=0 immediately, state IDLE, ack ignored, read-data=0.
